// File: rtl/sha256_multiblock_engine.sv
// SHA-256 engine for word-aligned messages of NUM_WORDS 32-bit words.
// Message words are streamed from memory. Padding and length words are made
// on the fly. Each block takes one round per cycle with a rolling 16-word
// schedule window. The digest H0..H7 is written back to memory at output_addr.
// Handshake: start is sampled only in IDLE. busy is high from the cycle after
// start until the done cycle. done is a one-cycle pulse and coincides with the
// return to IDLE, so a new start can be accepted in that same cycle.
// Memory: mem_addr and mem_we are registered. Read data is valid one cycle
// after the address is presented.
module sha256_multiblock_engine #(
    parameter int NUM_WORDS = 20,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic [2:0]        state_dbg
);

    localparam int          NUM_BLOCKS = (NUM_WORDS + 18) / 16;
    localparam logic [31:0] MSG_WORDS  = 32'(NUM_WORDS);
    localparam logic [31:0] LAST_BASE  = 32'(16 * (NUM_BLOCKS - 1));
    localparam logic [31:0] LEN_IDX    = 32'(16 * NUM_BLOCKS - 1);
    localparam logic [31:0] LEN_WORD   = 32'(NUM_WORDS * 32);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        COMPUTE = 3'd2,
        UPDATE  = 3'd3,
        WRITE   = 3'd4
    } state_t;

    state_t            state;
    logic [6:0]        cnt;        // cycle index within READ / COMPUTE / WRITE
    logic [31:0]       word_base;  // global index of word 0 of the current block
    logic [ADDR_W-1:0] msg_base;
    logic [ADDR_W-1:0] out_base;
    logic [31:0]       h_reg [8];
    logic [31:0]       v     [8];  // working variables a..h
    logic [31:0]       win   [16]; // rolling schedule window, win[0] is oldest

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign mem_clk   = clk;
    assign state_dbg = state;

    logic [31:0] issue_idx;
    logic [31:0] cap_idx;
    logic [31:0] cap_word;
    logic [31:0] sched_w;
    logic [31:0] round_w;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] next_base;
    logic [2:0]  wr_idx;

    // Word selection, message schedule and round arithmetic for the current cycle.
    always_comb begin
        // In READ cycle cnt the address for word cnt+1 is issued and word cnt-1 is captured.
        issue_idx = word_base + 32'(cnt) + 32'd1;
        cap_idx   = word_base + 32'(cnt) - 32'd1;
        if (cap_idx < MSG_WORDS) begin
            cap_word = mem_read_data;
        end else if (cap_idx == MSG_WORDS) begin
            cap_word = 32'h80000000;
        end else if (cap_idx == LEN_IDX) begin
            cap_word = LEN_WORD;
        end else begin
            cap_word = 32'h0;
        end
        // With the window holding W[t-16..t-1]: W[t-16]=win[0], W[t-15]=win[1],
        // W[t-7]=win[9], W[t-2]=win[14].
        sched_w   = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
        round_w   = (cnt < 7'd16) ? win[0] : sched_w;
        t1        = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt[5:0]] + round_w;
        t2        = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        next_base = word_base + 32'd16;
        wr_idx    = cnt[2:0] + 3'd1;
    end

    // Main FSM: sequences block loading, rounds, chaining update and digest write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= 7'd0;
            word_base      <= 32'd0;
            msg_base       <= '0;
            out_base       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= 32'd0;
                v[i]     <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_base  <= message_addr;
                        out_base  <= output_addr;
                        h_reg     <= IV;
                        word_base <= 32'd0;
                        cnt       <= 7'd0;
                        busy      <= 1'b1;
                        // Word 0 always exists, so its address is issued right away.
                        mem_addr  <= message_addr;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (cnt != 7'd0) begin
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i + 1];
                        end
                        win[15] <= cap_word;
                    end
                    // Padding slots keep the last (legal) address so no read goes past the message.
                    if (cnt < 7'd15 && issue_idx < MSG_WORDS) begin
                        mem_addr <= msg_base + issue_idx[ADDR_W-1:0];
                    end
                    if (cnt == 7'd16) begin
                        v     <= h_reg;
                        cnt   <= 7'd0;
                        state <= COMPUTE;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                COMPUTE: begin
                    // Rounds 0..15 rotate the window so it holds W[0..15] again at round 16.
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i + 1];
                    end
                    win[15] <= round_w;
                    v[7] <= v[6];
                    v[6] <= v[5];
                    v[5] <= v[4];
                    v[4] <= v[3] + t1;
                    v[3] <= v[2];
                    v[2] <= v[1];
                    v[1] <= v[0];
                    v[0] <= t1 + t2;
                    if (cnt == 7'd63) begin
                        cnt   <= 7'd0;
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= h_reg[i] + v[i];
                    end
                    word_base <= next_base;
                    cnt       <= 7'd0;
                    if (word_base == LAST_BASE) begin
                        // H0 is written in the first WRITE cycle, so present it now.
                        mem_we         <= 1'b1;
                        mem_addr       <= out_base;
                        mem_write_data <= h_reg[0] + v[0];
                        state          <= WRITE;
                    end else begin
                        if (next_base < MSG_WORDS) begin
                            mem_addr <= msg_base + next_base[ADDR_W-1:0];
                        end
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (cnt == 7'd7) begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        cnt    <= 7'd0;
                        state  <= IDLE;
                    end else begin
                        mem_addr       <= out_base + ADDR_W'(wr_idx);
                        mem_write_data <= h_reg[wr_idx];
                        cnt            <= cnt + 7'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_multiblock_engine.sv
// Bench for sha256_multiblock_engine: four instances (NUM_WORDS 20, 13, 14, 16)
// share one word memory. Each hash is compared against a plain SHA-256 model
// built from the padding rule and the full 64-word schedule.
module tb_sha256_multiblock_engine;

    localparam int ND = 4;
    localparam int NW_LIST [ND] = '{20, 13, 14, 16};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT instances ----------------
    logic        start_v [ND];
    logic [15:0] maddr_v [ND];
    logic [15:0] oaddr_v [ND];
    logic        busy_v  [ND];
    logic        done_v  [ND];
    logic        mclk_v  [ND];
    logic        we_v    [ND];
    logic [15:0] addr_v  [ND];
    logic [31:0] wdata_v [ND];
    logic [31:0] rdata_v [ND];
    logic [2:0]  st_v    [ND];

    for (genvar k = 0; k < ND; k++) begin : g_dut
        sha256_multiblock_engine #(
            .NUM_WORDS(NW_LIST[k]),
            .ADDR_W   (16)
        ) dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (start_v[k]),
            .message_addr  (maddr_v[k]),
            .output_addr   (oaddr_v[k]),
            .busy          (busy_v[k]),
            .done          (done_v[k]),
            .mem_clk       (mclk_v[k]),
            .mem_we        (we_v[k]),
            .mem_addr      (addr_v[k]),
            .mem_write_data(wdata_v[k]),
            .mem_read_data (rdata_v[k]),
            .state_dbg     (st_v[k])
        );
    end

    // ---------------- memory model (read data one cycle after address) ----------------
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) begin
            rdata_v[k] <= mem[addr_v[k]];
        end
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q [$];
    logic [47:0] wr_q  [$];
    logic [15:0] mbase_act [ND];
    bit          seen [ND][32];
    int          oor  [ND];
    int          done_cnt [ND];
    int          exp_lat;
    logic [15:0] mon_off;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: logs writes, records which message words were addressed,
    // counts any address outside the message while reading.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (we_v[k]) wr_q.push_back({addr_v[k], wdata_v[k]});
            if (busy_v[k] && !we_v[k]) begin
                mon_off = addr_v[k] - mbase_act[k];
                if (int'(mon_off) >= NW_LIST[k]) oor[k]++;
                else seen[k][mon_off[4:0]] = 1'b1;
            end
            if (done_v[k]) done_cnt[k]++;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] m_q [$];
    logic [31:0] m_w [64];
    logic [31:0] m_h [8];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic model_block(input int base);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) m_w[t] = m_q[base + t];
            else m_w[t] = (rr(m_w[t-2], 17) ^ rr(m_w[t-2], 19) ^ (m_w[t-2] >> 10)) + m_w[t-7]
                        + (rr(m_w[t-15], 7) ^ rr(m_w[t-15], 18) ^ (m_w[t-15] >> 3)) + m_w[t-16];
        end
        a = m_h[0]; b = m_h[1]; c = m_h[2]; d = m_h[3];
        e = m_h[4]; f = m_h[5]; g = m_h[6]; h = m_h[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + m_w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        m_h[0] += a; m_h[1] += b; m_h[2] += c; m_h[3] += d;
        m_h[4] += e; m_h[5] += f; m_h[6] += g; m_h[7] += h;
    endtask

    task automatic model_run();
        m_h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int b = 0; b < m_q.size(); b += 16) model_block(b);
    endtask

    // ---------------- driver tasks ----------------
    task automatic prep(input int k, input logic [15:0] mb, input logic [15:0] ob, input bit counting);
        logic [31:0] w;
        int n;
        n = NW_LIST[k];
        m_q.delete();
        for (int i = 0; i < n; i++) begin
            w = counting ? 32'h01010101 * i : $urandom();
            mem[16'(mb + 16'(i))] = w;
            m_q.push_back(w);
        end
        m_q.push_back(32'h80000000);
        while (m_q.size() % 16 != 14) m_q.push_back(32'h0);
        m_q.push_back(32'h0);
        m_q.push_back(32'(n * 32));
        model_run();
        exp_lat = 82 * (m_q.size() / 16) + 9;
        exp_q.delete();
        wr_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(ob + 16'(i)), m_h[i]});
        mbase_act[k] = mb;
        maddr_v[k]   = mb;
        oaddr_v[k]   = ob;
        for (int i = 0; i < 32; i++) seen[k][i] = 1'b0;
        oor[k] = 0;
    endtask

    // Called just after a falling edge: start is high for exactly one cycle.
    task automatic launch(input int k, output int c0);
        start_v[k] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    // Waits (bounded) for done; optionally re-pulses start while busy.
    task automatic wait_done(input int k, input int c0, input string tag, input bit extra);
        int bound;
        bound = exp_lat + 40;
        while (!done_v[k] && (cyc - c0) < bound) begin
            if (extra && ((cyc - c0) == 5 || (cyc - c0) == 100)) begin
                start_v[k] = 1'b1;
                check($sformatf("%s busy_at_%0d", tag, cyc - c0), busy_v[k], 1'b1);
            end else begin
                start_v[k] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[k] = 1'b0;
        check({tag, " done_latency"}, done_v[k] ? (cyc - c0) : -1, exp_lat);
    endtask

    task automatic verify_run(input int k, input string tag);
        int nseen;
        logic [47:0] got, want;
        check({tag, " write_count"}, wr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            want = exp_q.pop_front();
            got  = (wr_q.size() > 0) ? wr_q.pop_front() : 48'h0;
            check($sformatf("%s H%0d", tag, i), got, want);
        end
        nseen = 0;
        for (int i = 0; i < 32; i++) if (seen[k][i]) nseen++;
        check({tag, " distinct_reads"}, nseen, NW_LIST[k]);
        check({tag, " reads_outside_msg"}, oor[k], 0);
    endtask

    task automatic full_run(input int k, input string tag, input logic [15:0] mb, input logic [15:0] ob, input bit counting);
        int c0;
        prep(k, mb, ob, counting);
        launch(k, c0);
        check({tag, " busy_after_start"}, busy_v[k], 1'b1);
        wait_done(k, c0, tag, 1'b0);
        verify_run(k, tag);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done_v[k], 1'b0);
        check({tag, " busy_low_after"}, busy_v[k], 1'b0);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int snap;
        reset_n = 1'b0;
        for (int k = 0; k < ND; k++) begin
            start_v[k] = 1'b0; maddr_v[k] = 16'h0; oaddr_v[k] = 16'h0;
            mbase_act[k] = 16'h0; oor[k] = 0; done_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset values
        for (int k = 0; k < ND; k++) begin
            check($sformatf("rst%0d busy", k), busy_v[k], 1'b0);
            check($sformatf("rst%0d done", k), done_v[k], 1'b0);
            check($sformatf("rst%0d we", k), we_v[k], 1'b0);
            check($sformatf("rst%0d addr", k), addr_v[k], 16'h0);
            check($sformatf("rst%0d wdata", k), wdata_v[k], 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Model self-test on the one-block "abc" message
        m_q.delete();
        m_q.push_back(32'h61626380);
        for (int i = 0; i < 14; i++) m_q.push_back(32'h0);
        m_q.push_back(32'h18);
        model_run();
        check("model abc H0", m_h[0], 32'hba7816bf);
        check("model abc H7", m_h[7], 32'hf20015ad);

        // 1: N=20, counting pattern, two blocks
        full_run(0, "n20", 16'h0000, 16'h0100, 1'b1);
        // 2: N=13, one block, message wraps around the address space
        full_run(1, "n13", 16'hFFF8, 16'h0200, 1'b0);
        // 3: N=14, length word lands in a padding-only block
        full_run(2, "n14", 16'h1234, 16'h0300, 1'b0);
        // 4: N=16, pad word starts block 1
        full_run(3, "n16", 16'h2000, 16'h0400, 1'b0);

        // 5: extra start pulses while busy, then back-to-back start in the done cycle
        snap = done_cnt[0];
        prep(0, 16'h3000, 16'h0500, 1'b0);
        launch(0, c0);
        wait_done(0, c0, "multi", 1'b1);
        verify_run(0, "multi");
        prep(0, 16'h3100, 16'h0540, 1'b0);
        launch(0, c0);
        check("b2b busy_after_start", busy_v[0], 1'b1);
        wait_done(0, c0, "b2b", 1'b0);
        verify_run(0, "b2b");
        @(negedge clk);
        check("b2b done_pulses", done_cnt[0] - snap, 2);

        // 6: reset during block 1 rounds, then restart
        prep(0, 16'h4000, 16'h0600, 1'b0);
        launch(0, c0);
        while ((cyc - c0) < 120) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst busy", busy_v[0], 1'b0);
        check("midrst done", done_v[0], 1'b0);
        check("midrst we", we_v[0], 1'b0);
        check("midrst addr", addr_v[0], 16'h0);
        check("midrst wdata", wdata_v[0], 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst no_writes", wr_q.size(), 0);
        check("midrst idle", busy_v[0], 1'b0);
        full_run(0, "restart", 16'h4000, 16'h0600, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
